// File: rtl/aggr_bank_pkg.sv
// Shared types and default sizes for the aggregation bank and its neighbours.
package aggr_bank_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned FV_LEN = 16;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned NODE_W = 7;

    typedef struct packed {
        logic                         sos;
        logic                         eos;
        logic [NODE_W-1:0]            node_id;
        logic [1:0][DATA_W-1:0]       fv_data;
    } edge_pe2bank_t;

    typedef struct packed {
        logic                         sos;
        logic                         eos;
        logic                         partial;
        logic [NODE_W-1:0]            node_id;
        logic [1:0][ACC_W-1:0]        data;
    } bank2output_t;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_STREAM = 2'd1,
        A_OVER   = 2'd2
    } a_state_e;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_SEND = 1'b1
    } d_state_e;

endpackage

// File: rtl/aggr_lane.sv
// One accumulator element: sign-extends an int8 and adds it with saturation.
module aggr_lane
    import aggr_bank_pkg::DATA_W;
#(
    parameter int unsigned W = aggr_bank_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [W-1:0]      acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W:0]   base;
    logic [W:0]   sum;

    // One guard bit is enough to detect overflow of a single int8 add.
    always_comb begin
        base  = clr_i ? '0 : {acc_q[W-1], acc_q};
        sum   = base + {{(W + 1 - DATA_W){data_i[DATA_W-1]}}, data_i};
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end
        if (en_i) begin
            if (sum[W] != sum[W-1]) begin
                acc_d = sum[W] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
            end else begin
                acc_d = sum[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/aggr_bank.sv
// Aggregation bank: sums neighbour feature vectors per node and drains the
// captured result to the output SRAM as a pair-per-beat stream.
module aggr_bank
    import aggr_bank_pkg::DATA_W, aggr_bank_pkg::a_state_e, aggr_bank_pkg::A_IDLE,
           aggr_bank_pkg::A_STREAM, aggr_bank_pkg::A_OVER, aggr_bank_pkg::d_state_e,
           aggr_bank_pkg::D_IDLE, aggr_bank_pkg::D_SEND;
#(
    parameter int unsigned FV_LEN = aggr_bank_pkg::FV_LEN,
    parameter int unsigned ACC_W  = aggr_bank_pkg::ACC_W,
    parameter int unsigned NODE_W = aggr_bank_pkg::NODE_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_sos,
    input  logic                   in_eos,
    input  logic [1:0][DATA_W-1:0] in_fv_data,
    input  logic [NODE_W-1:0]      in_node_id,
    input  logic                   in_done_aggr,
    input  logic                   in_wb_en,
    output logic                   out_valid,
    output logic                   out_sos,
    output logic                   out_eos,
    output logic [1:0][ACC_W-1:0]  out_data,
    output logic [NODE_W-1:0]      out_node_id,
    output logic                   out_partial,
    input  logic                   out_ready,
    output logic                   err_overrun,
    output logic                   err_proto
);

    localparam int unsigned BEATS = FV_LEN / 2;
    localparam int unsigned KW    = $clog2(BEATS + 1);
    localparam int unsigned JW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [1:0] rst_sync_q;
    logic       rst_n;

    a_state_e            a_state_q;
    logic [KW-1:0]       k_q;
    logic [NODE_W-1:0]   node_q;
    logic                task_open_q;
    logic                clr_pend_q;

    d_state_e                         d_state_q;
    logic [JW-1:0]                    j_q;
    logic [BEATS-1:0][1:0][ACC_W-1:0] buf_q;
    logic [BEATS-1:0][1:0][ACC_W-1:0] acc;

    logic          in_stream;
    logic          beat;
    logic [KW-1:0] idx;
    logic          fits;
    logic          cap;
    logic          new_task;
    logic          acc_clr;
    logic          acc_en;
    logic          node_err;
    logic          proto_hit;
    logic [JW-1:0] j_nxt;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // No input valid: every cycle inside a vector is a beat.
    always_comb begin
        in_stream = (a_state_q == A_STREAM) || (a_state_q == A_OVER);
        beat      = in_sos || in_stream;
        idx       = in_sos ? '0 : k_q;
        fits      = idx < KW'(BEATS);
        cap       = in_done_aggr || in_wb_en;
        new_task  = in_sos && !task_open_q;
        acc_clr   = in_sos && clr_pend_q;
        acc_en    = beat && fits;
        node_err  = beat && task_open_q && (in_node_id != node_q);
        proto_hit = (beat && !fits) || node_err || (in_done_aggr && in_wb_en) ||
                    (cap && in_stream);
        j_nxt     = j_q + JW'(1);
    end

    for (genvar i = 0; i < FV_LEN; i++) begin : g_lane
        aggr_lane #(
            .W (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (acc_clr),
            .en_i   (acc_en && (idx == KW'(i / 2))),
            .data_i (in_fv_data[i % 2]),
            .acc_o  (acc[i / 2][i % 2])
        );
    end

    // Accumulator FSM, beat index, node latch and protocol error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state_q   <= A_IDLE;
            k_q         <= '0;
            node_q      <= '0;
            task_open_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            if (acc_en) begin
                k_q <= idx + KW'(1);
            end
            case (a_state_q)
                A_IDLE: begin
                    if (in_sos && !in_eos) begin
                        a_state_q <= A_STREAM;
                    end
                end
                A_STREAM, A_OVER: begin
                    if (in_eos) begin
                        a_state_q <= A_IDLE;
                    end else if (!fits) begin
                        a_state_q <= A_OVER;
                    end else begin
                        a_state_q <= A_STREAM;
                    end
                end
                default: begin
                    a_state_q <= A_IDLE;
                    k_q       <= '0;
                end
            endcase
            if (cap && in_stream) begin
                a_state_q <= A_IDLE;
            end
            if (cap) begin
                clr_pend_q  <= 1'b1;
                task_open_q <= 1'b0;
            end else if (in_sos) begin
                clr_pend_q  <= 1'b0;
                task_open_q <= 1'b1;
            end
            if (new_task) begin
                node_q <= in_node_id;
            end
            if (proto_hit) begin
                err_proto <= 1'b1;
            end
        end
    end

    // Drain FSM: a capture is only taken while idle; one pair per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_state_q   <= D_IDLE;
            j_q         <= '0;
            buf_q       <= '0;
            out_valid   <= 1'b0;
            out_sos     <= 1'b0;
            out_eos     <= 1'b0;
            out_data    <= '0;
            out_node_id <= '0;
            out_partial <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            case (d_state_q)
                D_IDLE: begin
                    if (cap) begin
                        d_state_q   <= D_SEND;
                        j_q         <= '0;
                        buf_q       <= acc;
                        out_valid   <= 1'b1;
                        out_sos     <= 1'b1;
                        out_eos     <= (BEATS == 1);
                        out_data    <= acc[0];
                        out_node_id <= node_q;
                        out_partial <= in_wb_en;
                    end
                end
                D_SEND: begin
                    if (cap) begin
                        err_overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        if (out_eos) begin
                            d_state_q   <= D_IDLE;
                            j_q         <= '0;
                            out_valid   <= 1'b0;
                            out_sos     <= 1'b0;
                            out_eos     <= 1'b0;
                            out_data    <= '0;
                            out_node_id <= '0;
                            out_partial <= 1'b0;
                        end else begin
                            j_q      <= j_nxt;
                            out_sos  <= 1'b0;
                            out_eos  <= (j_nxt == JW'(BEATS - 1));
                            out_data <= buf_q[j_nxt];
                        end
                    end
                end
                default: begin
                    d_state_q   <= D_IDLE;
                    j_q         <= '0;
                    out_valid   <= 1'b0;
                    out_sos     <= 1'b0;
                    out_eos     <= 1'b0;
                    out_data    <= '0;
                    out_node_id <= '0;
                    out_partial <= 1'b0;
                end
            endcase
        end
    end

endmodule
